// File: rtl/tmds_pkg.sv
// Shared TMDS constants, stage-1 record type and the popcount helper used by
// every encoder channel.
package tmds_pkg;

   localparam int unsigned CNT_W = 5;

   localparam logic [9:0] CTRL_00   = 10'b1101010100;
   localparam logic [9:0] CTRL_01   = 10'b0010101011;
   localparam logic [9:0] CTRL_10   = 10'b0101010100;
   localparam logic [9:0] CTRL_11   = 10'b1010101011;
   localparam logic [9:0] RESET_SYM = CTRL_00;

   typedef struct packed {
      logic [8:0] qm;
      logic [3:0] n1;
      logic       de;
      logic       c1;
      logic       c0;
   } tmds_s1_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_encoder_ch.sv
// Single-channel TMDS 8b/10b encoder: stage 1 builds q_m, stage 2 applies
// DC balancing with a per-channel running disparity counter.
module tmds_encoder_ch
   import tmds_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_d,
   input  logic       i_de,
   input  logic       i_c1,
   input  logic       i_c0,
   output logic [9:0] o_sym
);

   logic [3:0]              w_n1d;
   logic                    w_use_xnor;
   logic [8:0]              w_qm;
   tmds_s1_t                r_s1;
   logic signed [CNT_W-1:0] r_cnt;
   logic signed [CNT_W-1:0] w_cnt_nxt;
   logic signed [CNT_W-1:0] w_diff;
   logic [CNT_W-1:0]        w_n1x2;
   logic                    w_cnt_pos;
   logic                    w_cnt_neg;
   logic                    w_q8;
   logic [9:0]              r_sym;
   logic [9:0]              w_sym_nxt;

   always_comb begin
      w_n1d      = popcount8(i_d);
      w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !i_d[0]);
      w_qm       = '0;
      w_qm[0]    = i_d[0];
      for (int unsigned i = 1; i < 8; i++) begin
         w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ i_d[i]) : (w_qm[i-1] ^ i_d[i]);
      end
      w_qm[8]    = ~w_use_xnor;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
      end else begin
         r_s1 <= '{qm: w_qm, n1: popcount8(w_qm[7:0]), de: i_de, c1: i_c1, c0: i_c0};
      end
   end

   always_comb begin
      w_q8      = r_s1.qm[8];
      // N1 - N0 = 2*N1 - 8, kept modulo 2^CNT_W like the counter itself
      w_n1x2    = {r_s1.n1, 1'b0};
      w_diff    = $signed(w_n1x2 - 5'd8);
      w_cnt_pos = !r_cnt[CNT_W-1] && (r_cnt != '0);
      w_cnt_neg = r_cnt[CNT_W-1];
      w_sym_nxt = RESET_SYM;
      w_cnt_nxt = '0;
      if (!r_s1.de) begin
         case ({r_s1.c1, r_s1.c0})
            2'b00:   w_sym_nxt = CTRL_00;
            2'b01:   w_sym_nxt = CTRL_01;
            2'b10:   w_sym_nxt = CTRL_10;
            default: w_sym_nxt = CTRL_11;
         endcase
      end else if ((r_cnt == '0) || (r_s1.n1 == 4'd4)) begin
         w_sym_nxt = {~w_q8, w_q8, w_q8 ? r_s1.qm[7:0] : ~r_s1.qm[7:0]};
         w_cnt_nxt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if ((w_cnt_pos && (r_s1.n1 > 4'd4)) || (w_cnt_neg && (r_s1.n1 < 4'd4))) begin
         w_sym_nxt = {1'b1, w_q8, ~r_s1.qm[7:0]};
         w_cnt_nxt = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_diff;
      end else begin
         w_sym_nxt = {1'b0, w_q8, r_s1.qm[7:0]};
         w_cnt_nxt = r_cnt + w_diff - (w_q8 ? 5'sd0 : 5'sd2);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sym <= RESET_SYM;
         r_cnt <= '0;
      end else begin
         r_sym <= w_sym_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_sym = r_sym;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI TMDS encoder; sync is carried on blue, red/green send
// the C1C0=00 control symbol during blanking.
module tmds_encoder_3ch #(
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic       pixclk,
   input  logic       rst_n,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       de,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] TMDS_red,
   output logic [9:0] TMDS_green,
   output logic [9:0] TMDS_blue
);

   if (PIPE_LAT != 2) begin : g_lat_check
      $error("tmds_encoder_3ch: only PIPE_LAT=2 is supported");
   end

   tmds_encoder_ch u_red (
      .i_clk   (pixclk),
      .i_rst_n (rst_n),
      .i_d     (red),
      .i_de    (de),
      .i_c1    (1'b0),
      .i_c0    (1'b0),
      .o_sym   (TMDS_red)
   );

   tmds_encoder_ch u_green (
      .i_clk   (pixclk),
      .i_rst_n (rst_n),
      .i_d     (green),
      .i_de    (de),
      .i_c1    (1'b0),
      .i_c0    (1'b0),
      .o_sym   (TMDS_green)
   );

   tmds_encoder_ch u_blue (
      .i_clk   (pixclk),
      .i_rst_n (rst_n),
      .i_d     (blue),
      .i_de    (de),
      .i_c1    (vsync),
      .i_c0    (hsync),
      .o_sym   (TMDS_blue)
   );

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Randomized bench for tmds_encoder_3ch against a byte-level TMDS reference
// model; also checks decodability and running disparity of emitted symbols.
module tb_tmds_encoder_3ch;

   localparam logic [9:0] C00 = 10'h354;
   localparam logic [9:0] C01 = 10'h0AB;
   localparam logic [9:0] C10 = 10'h154;
   localparam logic [9:0] C11 = 10'h2AB;

   logic       pixclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] red    = '0;
   logic [7:0] green  = '0;
   logic [7:0] blue   = '0;
   logic       de     = 1'b0;
   logic       hsync  = 1'b0;
   logic       vsync  = 1'b0;
   logic [9:0] TMDS_red;
   logic [9:0] TMDS_green;
   logic [9:0] TMDS_blue;

   int n_checks = 0;
   int n_errors = 0;

   tmds_encoder_3ch #(.PIPE_LAT(2)) u_dut (
      .pixclk     (pixclk),
      .rst_n      (rst_n),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .de         (de),
      .hsync      (hsync),
      .vsync      (vsync),
      .TMDS_red   (TMDS_red),
      .TMDS_green (TMDS_green),
      .TMDS_blue  (TMDS_blue)
   );

   always #5 pixclk = ~pixclk;

   logic [9:0]        obs [3];
   logic signed [4:0] dut_cnt [3];
   assign obs[0] = TMDS_red;
   assign obs[1] = TMDS_green;
   assign obs[2] = TMDS_blue;
   assign dut_cnt[0] = u_dut.u_red.r_cnt;
   assign dut_cnt[1] = u_dut.u_green.r_cnt;
   assign dut_cnt[2] = u_dut.u_blue.r_cnt;

   // reference model state: one pending input record plus the output register
   logic [9:0] m_exp [3];
   int         m_cnt [3];
   logic [7:0] m_byte [3];
   logic       m_out_de;
   logic [7:0] p_pix [3];
   logic       p_de, p_hs, p_vs;

   function automatic int ones(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return C00;
         2'b01:   return C01;
         2'b10:   return C10;
         default: return C11;
      endcase
   endfunction

   function automatic void model_encode(input logic [7:0] d, input int cin,
                                        output logic [9:0] sym, output int cout);
      logic [8:0] qm;
      int         n1d, n1, n0, q8;
      bit         xn;
      n1d   = ones({2'b00, d});
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      q8    = int'(qm[8]);
      n1    = ones({2'b00, qm[7:0]});
      n0    = 8 - n1;
      if (cin == 0 || n1 == n0) begin
         sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cout = cin + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
      end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
         sym  = {1'b1, qm[8], ~qm[7:0]};
         cout = cin + 2 * q8 + (n0 - n1);
      end else begin
         sym  = {1'b0, qm[8], qm[7:0]};
         cout = cin + (n1 - n0) - 2 * (1 - q8);
      end
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   task automatic model_tick;
      if (!rst_n) begin
         for (int ch = 0; ch < 3; ch++) begin
            m_exp[ch] = C00;
            m_cnt[ch] = 0;
         end
         m_out_de = 1'b0;
         p_de = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
      end else begin
         m_out_de = p_de;
         for (int ch = 0; ch < 3; ch++) begin
            if (p_de) begin
               model_encode(p_pix[ch], m_cnt[ch], m_exp[ch], m_cnt[ch]);
               m_byte[ch] = p_pix[ch];
            end else begin
               m_cnt[ch] = 0;
               m_exp[ch] = (ch == 2) ? ctrl_sym(p_vs, p_hs) : C00;
            end
         end
         p_pix[0] = red; p_pix[1] = green; p_pix[2] = blue;
         p_de = de; p_hs = hsync; p_vs = vsync;
      end
   endtask

   // inputs change only after this returns, so the model sees what the DUT sampled
   task automatic step;
      @(posedge pixclk);
      model_tick();
      #1;
   endtask

   task automatic rand_pixel;
      red   = 8'($urandom);
      green = 8'($urandom);
      blue  = 8'($urandom);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rand_pixel();
         de = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
         step();
         for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs[ch] !== C00) begin
               n_errors++;
               $display("FAIL reset_sym ch%0d cyc%0d got %h want %h", ch, k, obs[ch], C00);
            end
            n_checks++;
            if (int'(dut_cnt[ch]) != 0) begin
               n_errors++;
               $display("FAIL reset_cnt ch%0d got %0d want 0", ch, dut_cnt[ch]);
            end
         end
      end
      rst_n = 1'b1; de = 1'b0; hsync = 1'b1; vsync = 1'b0;
      step();
      for (int ch = 0; ch < 3; ch++) begin
         n_checks++;
         if (obs[ch] !== C00) begin
            n_errors++;
            $display("FAIL reset_release1 ch%0d got %h want %h", ch, obs[ch], C00);
         end
      end
      step();
      for (int ch = 0; ch < 3; ch++) begin
         n_checks++;
         if (obs[ch] !== ((ch == 2) ? C01 : C00)) begin
            n_errors++;
            $display("FAIL reset_release2 ch%0d got %h want %h", ch, obs[ch],
                     (ch == 2) ? C01 : C00);
         end
      end
   endtask

   task automatic test_control_sweep;
      logic [9:0] tab [4];
      int         prev;
      tab[0] = C00; tab[1] = C01; tab[2] = C10; tab[3] = C11;
      de = 1'b0;
      for (int j = 0; j < 6; j++) begin
         {vsync, hsync} = (j < 4) ? 2'(j) : 2'd3;
         step();
         if (j >= 1) begin
            prev = (j - 1 < 4) ? (j - 1) : 3;
            n_checks++;
            if (TMDS_blue !== tab[prev]) begin
               n_errors++;
               $display("FAIL ctrl_blue idx%0d got %h want %h", prev, TMDS_blue, tab[prev]);
            end
            n_checks++;
            if (TMDS_red !== C00 || TMDS_green !== C00) begin
               n_errors++;
               $display("FAIL ctrl_rg idx%0d got %h/%h want %h", prev, TMDS_red, TMDS_green, C00);
            end
         end
      end
   endtask

   task automatic test_dc_balance_zeros;
      logic [9:0] want_sym [3];
      int         want_cnt [3];
      want_sym[0] = 10'h100; want_sym[1] = 10'h3FF; want_sym[2] = 10'h100;
      want_cnt[0] = -8;      want_cnt[1] = 2;       want_cnt[2] = -6;
      de = 1'b0; hsync = 1'b0; vsync = 1'b0;
      step(); step();
      for (int p = 0; p < 5; p++) begin
         if (p < 3) begin
            de = 1'b1; blue = 8'h00; red = 8'($urandom); green = 8'($urandom);
         end else begin
            de = 1'b0;
         end
         step();
         if (p >= 1 && p <= 3) begin
            n_checks++;
            if (TMDS_blue !== want_sym[p-1]) begin
               n_errors++;
               $display("FAIL zeros_sym px%0d got %h want %h", p - 1, TMDS_blue, want_sym[p-1]);
            end
            n_checks++;
            if (int'(dut_cnt[2]) != want_cnt[p-1]) begin
               n_errors++;
               $display("FAIL zeros_cnt px%0d got %0d want %0d", p - 1, dut_cnt[2], want_cnt[p-1]);
            end
            for (int ch = 0; ch < 2; ch++) begin
               n_checks++;
               if (obs[ch] !== m_exp[ch]) begin
                  n_errors++;
                  $display("FAIL zeros_rg ch%0d got %h want %h", ch, obs[ch], m_exp[ch]);
               end
            end
         end
         if (p == 4) begin
            n_checks++;
            if (int'(dut_cnt[2]) != 0 || TMDS_blue !== C00) begin
               n_errors++;
               $display("FAIL blank_clear got cnt %0d sym %h want cnt 0 sym %h",
                        dut_cnt[2], TMDS_blue, C00);
            end
         end
      end
   endtask

   task automatic test_all_ones;
      de = 1'b0; step(); step();
      de = 1'b1; red = 8'hFF; green = 8'($urandom); blue = 8'($urandom);
      step();
      de = 1'b0;
      step();
      n_checks++;
      if (TMDS_red !== 10'h200) begin
         n_errors++;
         $display("FAIL ones_sym got %h want %h", TMDS_red, 10'h200);
      end
      n_checks++;
      if (int'(dut_cnt[0]) != -8) begin
         n_errors++;
         $display("FAIL ones_cnt got %0d want -8", dut_cnt[0]);
      end
   endtask

   task automatic test_random_line;
      int sum [3];
      for (int ch = 0; ch < 3; ch++) sum[ch] = 0;
      de = 1'b0; step(); step();
      for (int k = 0; k < 1924; k++) begin
         if (k < 1920) begin
            de = 1'b1; rand_pixel();
         end else begin
            de = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom);
         end
         step();
         for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs[ch] !== m_exp[ch]) begin
               n_errors++;
               $display("FAIL line_sym k%0d ch%0d got %h want %h", k, ch, obs[ch], m_exp[ch]);
            end
            n_checks++;
            if (int'(dut_cnt[ch]) != m_cnt[ch]) begin
               n_errors++;
               $display("FAIL line_cnt k%0d ch%0d got %0d want %0d", k, ch, dut_cnt[ch], m_cnt[ch]);
            end
            if (m_out_de) begin
               sum[ch] += 2 * ones(obs[ch]) - 10;
               n_checks++;
               if (decode(obs[ch]) !== m_byte[ch]) begin
                  n_errors++;
                  $display("FAIL line_decode k%0d ch%0d got %h want %h", k, ch,
                           decode(obs[ch]), m_byte[ch]);
               end
               n_checks++;
               if (sum[ch] < -20 || sum[ch] > 20) begin
                  n_errors++;
                  $display("FAIL line_disparity k%0d ch%0d got %0d want within +/-20", k, ch, sum[ch]);
               end
            end else begin
               sum[ch] = 0;
            end
         end
      end
   endtask

   task automatic test_de_toggle;
      for (int k = 0; k < 64; k++) begin
         de = ((k % 2) == 0) || ((k % 7) == 0);
         rand_pixel();
         hsync = 1'($urandom); vsync = 1'($urandom);
         step();
         for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs[ch] !== m_exp[ch] || int'(dut_cnt[ch]) != m_cnt[ch]) begin
               n_errors++;
               $display("FAIL toggle k%0d ch%0d got %h/%0d want %h/%0d", k, ch,
                        obs[ch], dut_cnt[ch], m_exp[ch], m_cnt[ch]);
            end
         end
      end
   endtask

   task automatic test_reset_midline;
      de = 1'b1;
      for (int k = 0; k < 45; k++) begin
         rand_pixel();
         rst_n = (k == 20) ? 1'b0 : 1'b1;
         step();
         for (int ch = 0; ch < 3; ch++) begin
            n_checks++;
            if (obs[ch] !== m_exp[ch] || int'(dut_cnt[ch]) != m_cnt[ch]) begin
               n_errors++;
               $display("FAIL midrst k%0d ch%0d got %h/%0d want %h/%0d", k, ch,
                        obs[ch], dut_cnt[ch], m_exp[ch], m_cnt[ch]);
            end
            if (k == 20 || k == 21) begin
               n_checks++;
               if (obs[ch] !== C00) begin
                  n_errors++;
                  $display("FAIL midrst_sym k%0d ch%0d got %h want %h", k, ch, obs[ch], C00);
               end
            end
         end
      end
      rst_n = 1'b1; de = 1'b0;
      step(); step();
   endtask

   initial begin
      test_reset();
      test_control_sweep();
      test_dc_balance_zeros();
      test_all_ones();
      test_random_line();
      test_de_toggle();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
